// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: datapath width and
// the control-state encoding used by mul_ctrl, the datapath and the bench.
package mul_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mul_ctrl_if.sv
// Handshake/strobe bundle between the requester, mul_ctrl and the datapath.
// The master side issues start/abort and the operand bus; the slave is mul_ctrl.
interface mul_ctrl_if #(
    parameter int WIDTH = mul_pkg::WIDTH
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] din;
    logic             ldA;
    logic             ldP;
    logic             clrP;
    logic [WIDTH-1:0] b_cnt;
    logic             eqz;
    logic             busy;
    logic             done;
    logic             valid;

    modport master (
        output start, abort, din,
        input  ldA, ldP, clrP, b_cnt, eqz, busy, done, valid
    );

    modport slave (
        input  start, abort, din,
        output ldA, ldP, clrP, b_cnt, eqz, busy, done, valid
    );
endinterface

// File: rtl/mul_ctrl_cntr_b.sv
// Multiplier (B) down-counter: load, clear and non-wrapping decrement.
// Clear has priority over load, and load over decrement.
module cntr_b #(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ld,
    input  logic             i_dec,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_eqz
);
    logic [WIDTH-1:0] r_q;
    logic             w_eqz;

    assign w_eqz = (r_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end else if (i_dec && !w_eqz) begin
            r_q <= r_q - WIDTH'(1);
        end
    end

    assign o_q   = r_q;
    assign o_eqz = w_eqz;
endmodule

// File: rtl/mul_ctrl.sv
// Control path of the repeated-addition multiplier: sequences A/B capture from
// the shared bus, drives the PIPO2 clear/load strobes and owns the B counter.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input logic       clk,
    input logic       rst_n,
    mul_ctrl_if.slave bus
);
    state_t           r_state;
    logic             r_ldA;
    logic             r_ldP;
    logic             r_clrP;
    logic             r_done;
    logic             r_valid;
    logic             r_busy;
    logic [WIDTH-1:0] w_b_cnt;
    logic             w_eqz;
    logic             w_cnt_ld;
    logic             w_cnt_dec;

    assign w_cnt_ld  = (r_state == LDB);
    assign w_cnt_dec = (r_state == ADD);

    cntr_b #(.WIDTH(WIDTH)) u_cntr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ld  (w_cnt_ld),
        .i_dec (w_cnt_dec),
        .i_clr (bus.abort),
        .i_d   (bus.din),
        .o_q   (w_b_cnt),
        .o_eqz (w_eqz)
    );

    // Strobes are registered alongside the state, so each one is a pure
    // function of the state being entered and never of din/start directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ldA   <= 1'b0;
            r_ldP   <= 1'b0;
            r_clrP  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ldA  <= 1'b0;
            r_ldP  <= 1'b0;
            r_clrP <= 1'b0;
            r_done <= 1'b0;
            if (bus.abort) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_state <= LDA;
                            r_valid <= 1'b0;
                            r_ldA   <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    LDA: begin
                        r_state <= LDB;
                        r_clrP  <= 1'b1;
                    end
                    LDB: begin
                        if (bus.din == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ADD;
                            r_ldP   <= 1'b1;
                        end
                    end
                    ADD: begin
                        // Leaving on a count of 1 gives exactly B accumulations.
                        if (w_b_cnt == WIDTH'(1)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_ldP <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ldA   = r_ldA;
    assign bus.ldP   = r_ldP;
    assign bus.clrP  = r_clrP;
    assign bus.b_cnt = w_b_cnt;
    assign bus.eqz   = w_eqz;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.valid = r_valid;
endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: models the operand-A register and PIPO2/adder driven by
// the DUT strobes; a scoreboard queue holds hand-computed products per multiply.
module tb_mul_ctrl;
    import mul_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mul_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Datapath model: operand register plus PIPO2 accumulating A (mod 2^WIDTH).
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] p_reg;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            p_reg <= '0;
        end else begin
            if (bus.ldA) a_reg <= bus.din;
            if (bus.clrP) p_reg <= '0;
            else if (bus.ldP) p_reg <= p_reg + a_reg;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] prod;
        int               b;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts strobes per multiply and checks each done against the queue.
    int   ldp_cnt = 0;
    int   clr_cnt = 0;
    int   lda_cyc = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ldA) begin
                ldp_cnt = 0;
                clr_cnt = 0;
                lda_cyc = cyc;
            end
            if (bus.ldP) ldp_cnt++;
            if (bus.clrP) clr_cnt++;
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", bus.done, 1'b0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("product", p_reg, mon_e.prod);
                    check("ldP_cycles", ldp_cnt, mon_e.b);
                    check("clrP_pulses", clr_cnt, 1);
                    check("lda_to_done", cyc - lda_cyc, 2 + mon_e.b);
                    check("eqz_at_done", bus.eqz, 1'b1);
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  bus.busy,  1'b0);
        check({tag, "_b_cnt"}, bus.b_cnt, 0);
        check({tag, "_eqz"},   bus.eqz,   1'b1);
        check({tag, "_ldA"},   bus.ldA,   1'b0);
        check({tag, "_ldP"},   bus.ldP,   1'b0);
        check({tag, "_clrP"},  bus.clrP,  1'b0);
        check({tag, "_done"},  bus.done,  1'b0);
        check({tag, "_valid"}, bus.valid, 1'b0);
    endtask

    // Called at a negedge; returns at the negedge of the LDB cycle with B on din.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] prod, input bit hold, input bit push);
        int   n = 0;
        exp_t e;
        bus.start = 1'b1;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!bus.ldA && n < 4);
        check("accept_latency", n, 1);
        check("valid_low_at_lda", bus.valid, 1'b0);
        bus.din = a;
        if (!hold) bus.start = 1'b0;
        if (push) begin
            e.prod = prod;
            e.b    = int'(b);
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.din = b;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", bus.done, 1'b1);
        @(negedge clk);
        check("valid_after_done", bus.valid, 1'b1);
        check("done_one_cycle", bus.done, 1'b0);
        check("idle_after_done", bus.busy, 1'b0);
    endtask

    task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] prod, input bit hold);
        launch(a, b, prod, hold, 1'b1);
        wait_done(int'(b) + 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.din   = '0;

        repeat (2) @(negedge clk);
        check_reset_vals("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("after_release");

        run(16'h0011, 16'h0003, 16'h0033, 1'b0);
        run(16'h3454, 16'h0000, 16'h0000, 1'b0);

        // start held through the whole B=5 run, then re-accepted right after DONE.
        run(16'h0100, 16'h0005, 16'h0500, 1'b1);
        run(16'h0002, 16'h0002, 16'h0004, 1'b0);

        // Asynchronous reset in the second ADD cycle of a B=4 multiply.
        launch(16'h0001, 16'h0004, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        check("add1_b_cnt", bus.b_cnt, 16'h0004);
        check("add1_ldP", bus.ldP, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_add_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", bus.busy, 1'b0);

        // Abort in ADD with b_cnt == 2.
        launch(16'h0001, 16'h0005, 16'h0000, 1'b0, 1'b0);
        n = 0;
        while (bus.b_cnt != 16'h0002 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort_cnt_reached", bus.b_cnt, 16'h0002);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy",  bus.busy,  1'b0);
        check("abort_b_cnt", bus.b_cnt, 16'h0000);
        check("abort_valid", bus.valid, 1'b0);
        check("abort_ldP",   bus.ldP,   1'b0);
        check("abort_done",  bus.done,  1'b0);
        repeat (4) @(negedge clk);
        check("abort_no_done", bus.done, 1'b0);

        // start and abort together in IDLE.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        check("start_abort_busy", bus.busy, 1'b0);
        check("start_abort_ldA", bus.ldA, 1'b0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", bus.busy, 1'b0);

        run(16'h3456, 16'h0004, 16'hD158, 1'b0);
        run(16'hFFFF, 16'h0002, 16'hFFFE, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
